// File: rtl/button_conditioner_if.sv
// Button bundle between board pins and the cursor controller.
// Latency: n/a (wires only).
// Backpressure: none; outputs are single-cycle pulses or levels.
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_move;

  // Board/testbench side: drives raw buttons, consumes conditioned events.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_move
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_move
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect raw buttons; emit level/press/release/move.
// Latency: SYNC_STAGES+DB_CYCLES-1 edges from first high (or low) raw sample to output.
// Backpressure: none; pulses are one cycle wide and are not held for a consumer.
module button_conditioner #(
  parameter int                 N_BTN        = 5,
  parameter int                 SYNC_STAGES  = 2,
  parameter int                 DB_CYCLES    = 1_000_000,
  parameter int                 REPEAT_DELAY = 50_000_000,
  parameter int                 REPEAT_RATE  = 10_000_000,
  parameter logic [N_BTN-1:0]   REPEAT_MASK  = 5'b11110
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.slave   bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DB_PRESS = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] DB_REL   = 2'd3;

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_TERM   = DB_W'(DB_CYCLES);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE);

  logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
  logic [N_BTN-1:0]                  s;

  logic [1:0]       state_q   [N_BTN];
  logic [DB_W-1:0]  db_cnt_q  [N_BTN];
  logic [RPT_W-1:0] rpt_cnt_q [N_BTN];
  logic [N_BTN-1:0] first_rpt_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] move_q;

  // Shift raw inputs through the metastability synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel debounce / repeat FSM. Repeat counting only runs on masked-in
  // channels, so unmasked channels never count and cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= IDLE;
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
      end
      first_rpt_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      move_q      <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      move_q    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state_q[i])
          IDLE: begin
            if (s[i]) begin
              if (DB_CYCLES == 1) begin
                state_q[i]     <= HELD;
                level_q[i]     <= 1'b1;
                press_q[i]     <= 1'b1;
                move_q[i]      <= 1'b1;
                rpt_cnt_q[i]   <= '0;
                first_rpt_q[i] <= 1'b1;
              end else begin
                state_q[i]  <= DB_PRESS;
                db_cnt_q[i] <= DB_ONE;
              end
            end
          end
          DB_PRESS: begin
            if (!s[i]) begin
              state_q[i] <= IDLE;
            end else if (db_cnt_q[i] + DB_ONE == DB_TERM) begin
              state_q[i]     <= HELD;
              level_q[i]     <= 1'b1;
              press_q[i]     <= 1'b1;
              move_q[i]      <= 1'b1;
              rpt_cnt_q[i]   <= '0;
              first_rpt_q[i] <= 1'b1;
            end else begin
              db_cnt_q[i] <= db_cnt_q[i] + DB_ONE;
            end
          end
          HELD: begin
            if (!s[i]) begin
              // Repeat counter is frozen while the release is being debounced.
              if (DB_CYCLES == 1) begin
                state_q[i]   <= IDLE;
                level_q[i]   <= 1'b0;
                release_q[i] <= 1'b1;
              end else begin
                state_q[i]  <= DB_REL;
                db_cnt_q[i] <= DB_ONE;
              end
            end else if (REPEAT_MASK[i]) begin
              if (rpt_cnt_q[i] + RPT_ONE == (first_rpt_q[i] ? RPT_DELAY : RPT_RATE)) begin
                move_q[i]      <= 1'b1;
                rpt_cnt_q[i]   <= '0;
                first_rpt_q[i] <= 1'b0;
              end else begin
                rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_ONE;
              end
            end
          end
          default: begin // DB_REL
            if (s[i]) begin
              // Release glitch rejected; repeat counting resumes next cycle.
              state_q[i] <= HELD;
            end else if (db_cnt_q[i] + DB_ONE == DB_TERM) begin
              state_q[i]   <= IDLE;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
            end else begin
              db_cnt_q[i] <= db_cnt_q[i] + DB_ONE;
            end
          end
        endcase
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_move    = move_q;

endmodule
